// File: rtl/ula_entrada_ctrl.sv
// ula_entrada_ctrl -- operand/opcode entry controller for a board-driven ULA.
// Captures a, b and the op select from the switches on successive confirm
// presses, launches the ULA with a one-clock start pulse and flags valid
// once the ULA reports done. A clear press returns to operand-a entry.
// Optional build macro: ULA_ENTRADA_DEBOUNCE_EN adds a per-button debounce
// filter of DEBOUNCE_CYCLES clocks after the synchronizers; without it the
// synchronized level is used directly.
module ula_entrada_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sw,
  input  logic       btn_confirm,
  input  logic       btn_clear,
  input  logic       ula_done,
  output logic [7:0] a,
  output logic [7:0] b,
  output logic [2:0] sel_op,
  output logic       start,
  output logic       valid,
  output logic [2:0] estado
);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_DONE = 3'd4
  } state_e;

  // A zero-length debounce window has no meaning; this empty block makes
  // such a build visible by name in the elaborated hierarchy.
  if (DEBOUNCE_CYCLES < 1) begin : g_debounce_cycles_invalid
  end

  // Bit 0 is confirm, bit 1 is clear.
  logic [1:0] btn_raw;
  logic [1:0] press;
  assign btn_raw = {btn_clear, btn_confirm};

  // Counts the first clocks after reset until the synchronizer outputs
  // reflect real button samples rather than their cleared reset value.
  logic [1:0] settle_q;
  logic       settled;
  assign settled = (settle_q == 2'd3);

  // Post-reset settle counter, saturating.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      settle_q <= 2'd0;
    end else if (!settled) begin
      settle_q <= settle_q + 2'd1;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic sync1_q;
    logic sync2_q;
    logic level;
    logic prev_q;
    logic armed_q;
    logic press_q;

    // Two-flop synchronizer for the asynchronous button input.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
      end else begin
        sync1_q <= btn_raw[gi];
        sync2_q <= sync1_q;
      end
    end

`ifdef ULA_ENTRADA_DEBOUNCE_EN
    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    logic [CW-1:0] cnt_q;
    logic          level_q;

    // Accept a new level only after it has been seen for DEBOUNCE_CYCLES
    // consecutive clocks; any return to the old level restarts the count.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt_q   <= '0;
        level_q <= 1'b0;
      end else if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt_q   <= '0;
        level_q <= sync2_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign level = level_q;
`else
    assign level = sync2_q;
`endif

    // Rising-edge detect on the conditioned level. The detector only arms
    // after the button has been seen released, so a button held through
    // reset release cannot produce a press.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        prev_q  <= 1'b0;
        armed_q <= 1'b0;
        press_q <= 1'b0;
      end else begin
        prev_q  <= level;
        press_q <= level & ~prev_q & armed_q;
        if (settled && !sync2_q && !level) begin
          armed_q <= 1'b1;
        end
      end
    end

    assign press[gi] = press_q;
  end

  logic       confirm_p;
  logic       clear_p;
  assign confirm_p = press[0];
  assign clear_p   = press[1];

  logic [2:0] state_q;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic [2:0] sel_q;
  logic       start_q;
  logic       valid_q;

  // Entry sequencer: state plus registered operands, start and valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_A;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      sel_q   <= 3'd0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
    end else if (clear_p) begin
      // Clear outranks a coincident confirm.
      state_q <= S_A;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      sel_q   <= 3'd0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        S_A: begin
          valid_q <= 1'b0;
          if (confirm_p) begin
            a_q     <= sw;
            state_q <= S_B;
          end
        end
        S_B: begin
          valid_q <= 1'b0;
          if (confirm_p) begin
            b_q     <= sw;
            state_q <= S_OP;
          end
        end
        S_OP: begin
          valid_q <= 1'b0;
          if (confirm_p) begin
            sel_q   <= sw[2:0];
            start_q <= 1'b1;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          // ula_done is ignored in the start clock itself, since a ULA
          // with done tied high has not yet seen the new operands.
          valid_q <= 1'b0;
          if (!start_q && ula_done) begin
            valid_q <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          valid_q <= 1'b1;
          if (confirm_p) begin
            valid_q <= 1'b0;
            state_q <= S_A;
          end
        end
        default: begin
          // Unused codes fall back to operand-a entry.
          valid_q <= 1'b0;
          state_q <= S_A;
        end
      endcase
    end
  end

  assign a      = a_q;
  assign b      = b_q;
  assign sel_op = sel_q;
  assign start  = start_q;
  assign valid  = valid_q;
  assign estado = state_q;

endmodule

// File: tb/tb_ula_entrada_ctrl.sv
// Testbench for ula_entrada_ctrl: directed scenarios followed by random
// confirm/clear/done traffic, checked against a transaction-level model.
// Build with ULA_ENTRADA_DEBOUNCE_EN defined to include the bounce scenario.
module tb_ula_entrada_ctrl;

  localparam int HOLD = 14;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sw = 8'd0;
  logic       btn_confirm = 1'b0;
  logic       btn_clear = 1'b0;
  logic       ula_done = 1'b0;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] sel_op;
  logic       start;
  logic       valid;
  logic [2:0] estado;

  ula_entrada_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw          (sw),
    .btn_confirm (btn_confirm),
    .btn_clear   (btn_clear),
    .ula_done    (ula_done),
    .a           (a),
    .b           (b),
    .sel_op      (sel_op),
    .start       (start),
    .valid       (valid),
    .estado      (estado)
  );

  always #5 clk = ~clk;

  // Count clocks with start high, sampled mid-cycle.
  int start_cnt = 0;
  always @(negedge clk) begin
    if (start === 1'b1) start_cnt++;
  end

  int n_pass = 0;
  int n_total = 0;

  // Reference model: 0=A 1=B 2=OP 3=EXEC 4=DONE
  int       m_st = 0;
  int       m_a = 0;
  int       m_b = 0;
  int       m_op = 0;
  int       m_valid = 0;
  int       m_starts = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_zero();
    m_st = 0; m_a = 0; m_b = 0; m_op = 0; m_valid = 0;
  endtask

  task automatic model_press(input bit conf, input bit clr, input int swv, input bit done_lvl);
    if (clr) begin
      model_zero();
    end else if (conf) begin
      case (m_st)
        0: begin m_a = swv; m_st = 1; end
        1: begin m_b = swv; m_st = 2; end
        2: begin
          m_op = swv % 8; m_st = 3; m_starts++;
          if (done_lvl) begin m_st = 4; m_valid = 1; end
        end
        4: begin m_st = 0; m_valid = 0; end
        default: ;
      endcase
    end
  endtask

  // Press and release the chosen buttons with switches held at swv.
  task automatic press(input bit conf, input bit clr, input logic [7:0] swv);
    sw = swv;
    btn_confirm = conf;
    btn_clear = clr;
    tick(HOLD);
    btn_confirm = 1'b0;
    btn_clear = 1'b0;
    tick(HOLD);
    model_press(conf, clr, int'(swv), ula_done);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".estado"}, 32'(estado), 32'(m_st));
    chk({tag, ".a"}, 32'(a), 32'(m_a));
    chk({tag, ".b"}, 32'(b), 32'(m_b));
    chk({tag, ".sel_op"}, 32'(sel_op), 32'(m_op));
    chk({tag, ".valid"}, 32'(valid), 32'(m_valid));
    chk({tag, ".starts"}, 32'(start_cnt), 32'(m_starts));
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    model_zero();
    check_all("reset");
    chk("reset.start", 32'(start), 32'd0);
    tick(6);

    // Full capture sequence with ula_done tied high for the op step
    press(1'b1, 1'b0, 8'h12);
    press(1'b1, 1'b0, 8'h34);
    ula_done = 1'b1;
    press(1'b1, 1'b0, 8'h05);
    check_all("seq");
    chk("seq.a_lit", 32'(a), 32'h12);
    chk("seq.b_lit", 32'(b), 32'h34);
    chk("seq.op_lit", 32'(sel_op), 32'd5);
    chk("seq.estado_lit", 32'(estado), 32'd4);
    ula_done = 1'b0;

    // Confirm in DONE returns to A with operands retained
    press(1'b1, 1'b0, 8'hFF);
    check_all("done_exit");

    // Long wait in EXEC with ignored confirms
    press(1'b1, 1'b0, 8'hA1);
    press(1'b1, 1'b0, 8'hB2);
    press(1'b1, 1'b0, 8'h03);
    tick(50);
    for (int i = 0; i < 3; i++) press(1'b1, 1'b0, 8'h77);
    check_all("exec_wait");
    chk("exec_wait.estado_lit", 32'(estado), 32'd3);
    ula_done = 1'b1;
    tick(1);
    m_st = 4; m_valid = 1;
    check_all("exec_done");
    ula_done = 1'b0;
    tick(2);

    // Clear and confirm coincident in S_B
    press(1'b1, 1'b0, 8'h00);
    press(1'b1, 1'b0, 8'h9C);
    chk("pre_clear.estado", 32'(estado), 32'd1);
    press(1'b1, 1'b1, 8'h5A);
    check_all("clear_win");

    // Reset for one clock while in EXEC
    press(1'b1, 1'b0, 8'h11);
    press(1'b1, 1'b0, 8'h22);
    press(1'b1, 1'b0, 8'h06);
    chk("pre_rst.estado", 32'(estado), 32'd3);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    model_zero();
    check_all("mid_reset");
    tick(5);
    check_all("post_reset");
    tick(4);

    // Button held through reset release gives no press until re-pressed
    btn_confirm = 1'b1;
    sw = 8'h3C;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(20);
    check_all("held_reset");
    btn_confirm = 1'b0;
    tick(HOLD);
    check_all("held_release");
    press(1'b1, 1'b0, 8'h3C);
    check_all("held_repress");

    // Illegal state code recovers to S_A
    @(negedge clk);
    force dut.state_q = 3'd6;
    #1;
    release dut.state_q;
    chk("forced.estado", 32'(estado), 32'd6);
    tick(1);
    m_st = 0; m_valid = 0;
    check_all("recover");
    chk("recover.start", 32'(start), 32'd0);
    tick(2);

`ifdef ULA_ENTRADA_DEBOUNCE_EN
    // Bouncing confirm: only the final stable high is accepted
    sw = 8'hA5;
    for (int i = 0; i < 10; i++) begin
      btn_confirm = (i % 2 == 0);
      tick(2);
    end
    btn_confirm = 1'b1;
    tick(10);
    btn_confirm = 1'b0;
    tick(HOLD);
    model_press(1'b1, 1'b0, 32'hA5, 1'b0);
    check_all("bounce");
`endif

    // Random traffic
    for (int it = 0; it < 30; it++) begin
      int act;
      act = int'($urandom_range(0, 9));
      if (act == 0) begin
        press(1'b0, 1'b1, 8'($urandom));
      end else if (act <= 2) begin
        ula_done = 1'b1;
        tick(3);
        ula_done = 1'b0;
        tick(1);
        if (m_st == 3) begin m_st = 4; m_valid = 1; end
      end else begin
        press(1'b1, 1'b0, 8'($urandom));
      end
      check_all($sformatf("rand%0d", it));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
